// File: rtl/zero16.sv
// 16-bit all-zero detector: nibble NORs feed a 4-input AND (out), plus a registered copy (out_q).
// Define ZERO16_GATE_DELAY_EN for 50 ps gate and clk-to-q delays (timescale 1ps/1ps).
`timescale 1ps/1ps
module zero16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    output logic        out,
    output logic        out_q
);

    logic [3:0] nib_zero;

`ifdef ZERO16_GATE_DELAY_EN
    // NOR level and AND level each cost one gate delay, so in -> out is 100 ps.
    assign #50 nib_zero[0] = ~|in[3:0];
    assign #50 nib_zero[1] = ~|in[7:4];
    assign #50 nib_zero[2] = ~|in[11:8];
    assign #50 nib_zero[3] = ~|in[15:12];
    assign #50 out         = &nib_zero;

    // Reset forces the flag high at once; only the clocked load sees clk-to-q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            out_q <= 1'b1;
        else
            out_q <= #50 out;
    end
`else
    assign nib_zero[0] = ~|in[3:0];
    assign nib_zero[1] = ~|in[7:4];
    assign nib_zero[2] = ~|in[11:8];
    assign nib_zero[3] = ~|in[15:12];
    assign out         = &nib_zero;

    // Reset value 1 matches out for the cleared-operand state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            out_q <= 1'b1;
        else
            out_q <= out;
    end
`endif

endmodule

// File: tb/tb_zero16.sv
// Bench for zero16: one DUT slice inside a four-slice zero64 arrangement, scoreboard-checked.
`timescale 1ps/1ps
module tb_zero16;

    logic        clk;
    logic        reset;
    logic [63:0] bus;
    logic [3:0]  slice_out;
    logic [3:0]  slice_q;
    logic        z;

    int errors = 0;
    int checks = 0;

    logic exp_out_q[$];
    logic exp_reg_q[$];

    zero16 dut (.clk(clk), .reset(reset), .in(bus[15:0]),  .out(slice_out[0]), .out_q(slice_q[0]));
    zero16 u1  (.clk(clk), .reset(reset), .in(bus[31:16]), .out(slice_out[1]), .out_q(slice_q[1]));
    zero16 u2  (.clk(clk), .reset(reset), .in(bus[47:32]), .out(slice_out[2]), .out_q(slice_q[2]));
    zero16 u3  (.clk(clk), .reset(reset), .in(bus[63:48]), .out(slice_out[3]), .out_q(slice_q[3]));

    assign z = &slice_out;

    initial clk = 1'b0;
    always #500 clk = ~clk;

    function automatic logic ref_zero(input logic [15:0] v);
        logic r;
        r = 1'b1;
        for (int b = 0; b < 16; b++)
            if (v[b]) r = 1'b0;
        return r;
    endfunction

    task automatic test_reset;
        logic e;
        reset = 1'b1;
        bus   = 64'h0;
        #150;
        checks++;
        if (slice_q[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_out_q: got %b want 1", slice_q[0]);
        end
        checks++;
        if (slice_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_out: got %b want 1", slice_out[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_reg_q.push_back(1'b1);
        @(negedge clk);
        e = exp_reg_q.pop_front();
        checks++;
        if (slice_q[0] !== e) begin
            errors++;
            $display("FAIL release_out_q: got %b want %b", slice_q[0], e);
        end
    endtask

    task automatic test_zero_hold;
        logic e;
        @(negedge clk);
        bus = 64'h0;
        exp_out_q.push_back(1'b1);
        #5000;
        e = exp_out_q.pop_front();
        checks++;
        if (slice_out[0] !== e) begin
            errors++;
            $display("FAIL hold_zero_out: got %b want %b", slice_out[0], e);
        end
        exp_reg_q.push_back(1'b1);
        @(posedge clk);
        @(negedge clk);
        e = exp_reg_q.pop_front();
        checks++;
        if (slice_q[0] !== e) begin
            errors++;
            $display("FAIL hold_zero_out_q: got %b want %b", slice_q[0], e);
        end
    endtask

    // Drives each pattern, checks out after settling and out_q after the next edge.
    task automatic run_patterns(input string name, input logic [15:0] pats[$]);
        logic e;
        foreach (pats[i]) begin
            @(negedge clk);
            bus = {48'h0, pats[i]};
            exp_out_q.push_back(ref_zero(pats[i]));
            exp_reg_q.push_back(ref_zero(pats[i]));
            #150;
            e = exp_out_q.pop_front();
            checks++;
            if (slice_out[0] !== e) begin
                errors++;
                $display("FAIL %s_out[%h]: got %b want %b", name, pats[i], slice_out[0], e);
            end
            @(negedge clk);
            e = exp_reg_q.pop_front();
            checks++;
            if (slice_q[0] !== e) begin
                errors++;
                $display("FAIL %s_out_q[%h]: got %b want %b", name, pats[i], slice_q[0], e);
            end
        end
    endtask

    task automatic test_patterns;
        logic [15:0] p[$];
        p = '{16'h0755, 16'h0004, 16'h8000};
        run_patterns("pattern", p);
    endtask

    task automatic test_walking;
        logic [15:0] p[$];
        for (int b = 0; b < 16; b++)
            p.push_back(16'h1 << b);
        p.push_back(16'hFFFF);
        p.push_back(16'h0000);
        run_patterns("walk", p);
    endtask

    task automatic test_reset_midcycle;
        @(negedge clk);
        bus = {48'h0, 16'hFFFF};
        @(negedge clk);
        checks++;
        if (slice_q[0] !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_out_q: got %b want 0", slice_q[0]);
        end
        #100;
        reset = 1'b1;
        #1;
        checks++;
        if (slice_q[0] !== 1'b1) begin
            errors++;
            $display("FAIL midcycle_reset_out_q: got %b want 1", slice_q[0]);
        end
        #150;
        checks++;
        if (slice_out[0] !== 1'b0) begin
            errors++;
            $display("FAIL midcycle_reset_out: got %b want 0", slice_out[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (slice_q[0] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_out_q: got %b want 0", slice_q[0]);
        end
    endtask

    task automatic test_zero64;
        @(negedge clk);
        bus = 64'h0;
        #150;
        checks++;
        if (z !== 1'b1) begin
            errors++;
            $display("FAIL zero64_all_zero: got %b want 1", z);
        end
        bus = 64'h0000_0000_8000_0000;
        #150;
        checks++;
        if (z !== 1'b0) begin
            errors++;
            $display("FAIL zero64_bit31: got %b want 0", z);
        end
        checks++;
        if (slice_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL zero64_low_slice: got %b want 1", slice_out[0]);
        end
    endtask

`ifdef ZERO16_GATE_DELAY_EN
    task automatic test_gate_delay;
        @(negedge clk);
        bus = {48'h0, 16'h0001};
        #200;
        bus = 64'h0;
        #99;
        checks++;
        if (slice_out[0] !== 1'b0) begin
            errors++;
            $display("FAIL delay_t99: got %b want 0", slice_out[0]);
        end
        #2;
        checks++;
        if (slice_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL delay_t100: got %b want 1", slice_out[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_hold();
        test_patterns();
        test_walking();
        test_reset_midcycle();
        test_zero64();
`ifdef ZERO16_GATE_DELAY_EN
        test_gate_delay();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
